// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin request arbiters.
// Helpers work on a fixed 16-bit request space; callers zero-extend and truncate.
package rr_arb_pkg;

    localparam int MAX_REQ   = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Rotated search: look at ptr+1, ptr+2, ... (mod n) and return the first set bit.
    // Iterating from the far end lets the nearest hit overwrite the others.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                      input logic [MAX_IDX_W-1:0] ptr,
                                      input int                   n);
        pick_t      r;
        logic [4:0] j;
        r = '0;
        j = '0;
        for (int i = MAX_REQ; i >= 1; i--) begin
            if (i <= n) begin
                j = {1'b0, ptr} + 5'(i);
                if (j >= 5'(n)) begin
                    j = j - 5'(n);
                end
                if (req[j[3:0]]) begin
                    r.valid = 1'b1;
                    r.idx   = j[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_req_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req_i;
    logic             done_i;
    logic [N_REQ-1:0] gnt_o;
    logic [IDX_W-1:0] gnt_idx_o;
    logic             busy_o;
    logic             timeout_o;

    modport master (
        output req_i, done_i,
        input  gnt_o, gnt_idx_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i, done_i,
        output gnt_o, gnt_idx_o, busy_o, timeout_o
    );
endinterface

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping at N_REQ.
module rr_prio_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);
    pick_t pick;

    always_comb begin
        pick    = rr_pick(MAX_REQ'(req_i), MAX_IDX_W'(ptr_i), N_REQ);
        valid_o = pick.valid;
        idx_o   = IDX_W'(pick.idx);
    end
endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter with registered one-hot grant, bounded hold time and
// a mandatory idle cycle between consecutive grants.
module rr_req_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDX_W   = $clog2(N_REQ),
    localparam int HOLD_W  = $clog2(MAX_HOLD + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    rr_req_arbiter_if.slave   bus
);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic              hit_limit;
    logic              early_rel;
    logic              release_now;

    rr_prio_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i   (bus.req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // A grantee's own release (done or dropped request) takes precedence over the timeout.
    assign hit_limit   = (hold_q == HOLD_LAST);
    assign early_rel   = bus.done_i || !bus.req_i[idx_q];
    assign release_now = early_rel || hit_limit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            ptr_q     <= PTR_RST;
            gnt_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid)  state_d = BUSY;
            BUSY:    if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        idx_d     = idx_q;
        busy_d    = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d  = N_REQ'(onehot(MAX_IDX_W'(pick_idx)));
                    idx_d  = pick_idx;
                    busy_d = 1'b1;
                    ptr_d  = pick_idx;
                    hold_d = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    hold_d    = '0;
                    timeout_d = hit_limit && !early_rel;
                end else begin
                    hold_d = hold_q + 1'b1;
                    gnt_d  = gnt_q;
                    busy_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.gnt_idx_o = idx_q;
    assign bus.busy_o    = busy_q;
    assign bus.timeout_o = timeout_q;
endmodule
